// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume and optional auto-reload.
// Emits a single-cycle done pulse on the edge the count reaches terminal.
module countdown_timer #(
    parameter int unsigned BITSIZE = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic [BITSIZE-1:0] loadValue,
    input  logic               start,
    input  logic               pause,
    input  logic               autoReload,
    output logic [BITSIZE-1:0] countReg,
    output logic               running,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused
    } state_e;

    state_e             state_q, state_d;
    logic [BITSIZE-1:0] count_d;
    logic [BITSIZE-1:0] reload_q, reload_d;
    logic               done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = countReg;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            // A pending terminal is dropped: load wins over everything but reset.
            count_d  = loadValue;
            reload_d = loadValue;
            state_d  = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (countReg != '0)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPaused;
                    end else if (countReg > BITSIZE'(1)) begin
                        count_d = countReg - BITSIZE'(1);
                    end else if (countReg == BITSIZE'(1)) begin
                        done_d = 1'b1;
                        if (autoReload && (reload_q != '0)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        // Zero count in RUN is unreachable; recover to idle.
                        state_d = StIdle;
                    end
                end
                StPaused: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            countReg <= '0;
            reload_q <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            countReg <= count_d;
            reload_q <= reload_d;
            running  <= (state_d == StRun);
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized scoreboard bench for countdown_timer: an 8-bit and a 4-bit instance
// share one stimulus stream and are checked against a behavioural model.
module tb_countdown_timer;

    logic       CLK = 1'b0;
    logic       RST, load, start, pause, autoReload;
    logic [7:0] loadValue0;
    logic [3:0] loadValue1;
    logic [7:0] countReg0;
    logic [3:0] countReg1;
    logic       running0, running1, done0, done1;

    always #5 CLK = ~CLK;

    countdown_timer #(.BITSIZE(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .load(load), .loadValue(loadValue0), .start(start),
        .pause(pause), .autoReload(autoReload), .countReg(countReg0),
        .running(running0), .done(done0)
    );

    countdown_timer #(.BITSIZE(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .load(load), .loadValue(loadValue1), .start(start),
        .pause(pause), .autoReload(autoReload), .countReg(countReg1),
        .running(running1), .done(done1)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       run;
        logic       dn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    // Reference model: mode 0 = idle, 1 = counting, 2 = frozen.
    int m_cnt[2];
    int m_rel[2];
    int m_mode[2];

    function automatic exp_t model_step(int i, bit rst, bit ld, int lv, bit st, bit ps, bit ar);
        exp_t e;
        bit   dn = 1'b0;
        if (rst) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_mode[i] = 0;
        end else if (ld) begin
            m_cnt[i] = lv; m_rel[i] = lv; m_mode[i] = 0;
        end else if (m_mode[i] == 0) begin
            if (st && m_cnt[i] > 0) m_mode[i] = 1;
        end else if (m_mode[i] == 2) begin
            if (st) m_mode[i] = 1;
        end else if (ps) begin
            m_mode[i] = 2;
        end else if (m_cnt[i] > 1) begin
            m_cnt[i] = m_cnt[i] - 1;
        end else begin
            dn = 1'b1;
            if (ar && m_rel[i] > 0) begin
                m_cnt[i] = m_rel[i];
            end else begin
                m_cnt[i] = 0;
                m_mode[i] = 0;
            end
        end
        e.cnt = 8'(m_cnt[i]);
        e.run = (m_mode[i] == 1);
        e.dn  = dn;
        return e;
    endfunction

    task automatic drive(bit rst, bit ld, int lv, bit st, bit ps, bit ar);
        @(negedge CLK);
        RST = rst; load = ld; start = st; pause = ps; autoReload = ar;
        loadValue0 = 8'(lv);
        loadValue1 = 4'(lv);
        q0.push_back(model_step(0, rst, ld, lv & 255, st, ps, ar));
        q1.push_back(model_step(1, rst, ld, lv & 15, st, ps, ar));
    endtask

    task automatic idle(int n, bit ar);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, ar);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_done_count(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: done pulses seen %0d, required %0d", name, got, want);
        end
    endtask

    // Monitor: every edge the DUTs present outputs; compare against queued expectations.
    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (countReg0 !== e.cnt || running0 !== e.run || done0 !== e.dn) begin
                errors++;
                $display("FAIL w8 t=%0t: count=%0d running=%b done=%b, required count=%0d running=%b done=%b",
                         $time, countReg0, running0, done0, e.cnt, e.run, e.dn);
            end
            if (done0 === 1'b1) done_seen++;
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (countReg1 !== e.cnt[3:0] || running1 !== e.run || done1 !== e.dn) begin
                errors++;
                $display("FAIL w4 t=%0t: count=%0d running=%b done=%b, required count=%0d running=%b done=%b",
                         $time, countReg1, running1, done1, e.cnt[3:0], e.run, e.dn);
            end
        end
    end

    initial begin
        int d0;
        RST = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; autoReload = 1'b0;
        loadValue0 = '0; loadValue1 = '0;

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // Basic countdown from 5.
        drive(0, 1, 5, 0, 0, 0);
        d0 = done_seen;
        drive(0, 0, 0, 1, 0, 0);
        idle(7, 0);
        settle();
        check_done_count("single_run", done_seen - d0, 1);

        // Pause at 3 for four cycles, then resume.
        drive(0, 1, 6, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(3, 0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(5, 0);

        // Auto-reload period 3, then clear autoReload.
        drive(0, 1, 3, 0, 0, 1);
        d0 = done_seen;
        drive(0, 0, 0, 1, 0, 1);
        idle(9, 1);
        idle(5, 0);
        settle();
        check_done_count("reload_3", done_seen - d0, 4);

        // Period 1 reload, then zero load must never start.
        drive(0, 1, 1, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        idle(4, 1);
        drive(0, 1, 0, 0, 0, 0);
        d0 = done_seen;
        drive(0, 0, 0, 1, 0, 0);
        idle(4, 0);
        settle();
        check_done_count("load_zero", done_seen - d0, 0);

        // Reset mid-run, then load while count is 1.
        drive(0, 1, 8, 0, 0, 0);
        d0 = done_seen;
        drive(0, 0, 0, 1, 0, 0);
        idle(4, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(3, 0);
        drive(0, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(1, 0);
        drive(0, 1, 9, 0, 0, 0);
        idle(3, 0);
        settle();
        check_done_count("rst_and_load_abort", done_seen - d0, 0);

        // Full 4-bit period, and start+pause together in both run and frozen states.
        drive(0, 1, 15, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(17, 0);
        drive(0, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle(1, 0);
        drive(0, 0, 0, 1, 1, 0);
        idle(2, 0);
        drive(0, 0, 0, 1, 1, 0);
        idle(6, 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bit rst = ($urandom_range(0, 63) == 0);
            bit ld  = ($urandom_range(0, 15) == 0);
            int lv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 6));
            bit st  = ($urandom_range(0, 3) == 0);
            bit ps  = ($urandom_range(0, 7) == 0);
            bit ar  = $urandom_range(0, 1) == 1;
            drive(rst, ld, lv, st, ps, ar);
        end

        settle();
        settle();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/timer. Complements the team's up counter: software or an FSM loads a period, starts it, and gets a one-cycle `done` pulse when the count reaches terminal.
- Supports pause/resume and optional auto-reload for periodic ticks.
- Used as a timeout/tick generator next to control FSMs.
- Single clock domain, synchronous active-high reset.

Parameters:
- BITSIZE, 8: width of the count and load value.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- load  input  1  load `loadValue` into count and reload registers.
- loadValue  input  BITSIZE  period to load.
- start  input  1  start from IDLE, or resume from PAUSED.
- pause  input  1  freeze the count while in RUN.
- autoReload  input  1  on terminal count, reload and keep running.
- countReg  output  BITSIZE  current count (registered).
- running  output  1  high while state is RUN (registered).
- done  output  1  one-cycle pulse at terminal count (registered).

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high. No asynchronous logic.
- Reset values: state=IDLE, countReg=0, reloadReg=0, running=0, done=0.
- Input priority per edge: RST > load > start/pause.
- done default: 0 on every edge unless set by the terminal rule below, so it is always a single-cycle pulse.
- States: IDLE, RUN, PAUSED. `running` = 1 exactly when the next state is RUN, registered with the state.
- load, in any state:
  - countReg<=loadValue, reloadReg<=loadValue.
  - state<=IDLE, done<=0.
  - start/pause on the same edge are ignored.
- IDLE:
  - start && countReg!=0 -> RUN; countReg holds this edge.
  - start && countReg==0 -> stay IDLE; no done, no error.
  - pause is ignored.
- RUN, evaluated in order:
  - pause=1 -> PAUSED, countReg holds; start is ignored.
  - else countReg>1 -> countReg<=countReg-1.
  - else countReg==1 -> done<=1, then:
    - autoReload=1 and reloadReg!=0: countReg<=reloadReg, stay RUN.
    - otherwise: countReg<=0, state<=IDLE.
- PAUSED:
  - start -> RUN, count holds on that edge; decrementing resumes the next edge.
  - pause alone -> stay PAUSED. start+pause together -> RUN (start wins).
- Latency:
  - start sampled at edge N with count V (V>=1): countReg=V-k after edge N+k.
  - done is high for the cycle after edge N+V. Run length is exactly V cycles (without pauses).
- Auto-reload period: done pulses every reloadReg cycles. reloadReg=1 gives done high every cycle while running.
- Arithmetic: never decrements from 0, so no underflow or wrap is possible. Counting is unsigned; max period 2^BITSIZE-1.
- autoReload is sampled only at the terminal edge; changing it mid-run is legal.
- RST mid-run, or while done is high: everything returns to reset values on that edge; no done follows.
- load mid-run: new value loaded, state IDLE. A pending terminal does not fire, even if count==1 on the same edge.

Test Plan:
1. RST=1 for 2 edges, then load=1, loadValue=5, then start=1 for 1 cycle -> countReg 5,4,3,2,1,0 on successive edges; done=1 for exactly one cycle when countReg becomes 0; running drops the same edge; state IDLE.
2. Load 6, start, assert pause when countReg=3 for 4 cycles, then start -> countReg stays 3 for 4 cycles; running=0 while paused; resumes 2,1,0; done after 6 counting cycles total.
3. Load 3, autoReload=1, start -> sequence 3,2,1,3,2,1,...; done pulses every 3 cycles; running stays 1. Clear autoReload -> next terminal ends at 0, IDLE.
4. Load 1, autoReload=1, start -> done=1 every cycle, countReg constant 1. Load 0, then start -> stays IDLE, done never asserts.
5. Load 8, start, then RST=1 at countReg=4 -> next edge: countReg=0, running=0, done=0. Separately, load 9 while countReg=1 in RUN -> countReg=9, IDLE, no done pulse.
6. BITSIZE=4 instance: load 15, start -> 15 counting cycles then done. Verify start and pause together in RUN -> PAUSED (pause wins), and start and pause together in PAUSED -> RUN.
